// File: rtl/disp_msg_scheduler.sv
// disp_msg_scheduler: fixed-priority arbiter and write sequencer in front of
// the 4-digit seven-segment decoder. Grants one of error / number / prompt
// requests, drives the decoder strobe and message select, and holds error
// messages on screen for HOLD_CYCLES before restoring the last normal message.
module disp_msg_scheduler #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int TW          = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       val_req,
  input  logic [7:0] val_bin,
  input  logic       val_sgn,
  input  logic [1:0] val_dot,
  input  logic       prompt_req,
  input  logic [1:0] prompt_code,
  input  logic       err_req,
  output logic       val_ack,
  output logic       prompt_ack,
  output logic       err_ack,
  output logic [1:0] msg,
  output logic [7:0] bin,
  output logic       sgn,
  output logic [1:0] dot,
  output logic       wr_enable,
  output logic       led0_sel,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD     = 2'd1,
    S_ERR_HOLD = 2'd2
  } state_t;

  localparam logic [1:0]    MSG_NUM  = 2'b00;
  localparam logic [1:0]    MSG_OP   = 2'b01;
  localparam logic [1:0]    MSG_VAL  = 2'b10;
  localparam logic [1:0]    MSG_ERR  = 2'b11;
  localparam logic [TW-1:0] T_RELOAD = TW'(HOLD_CYCLES - 1);

  state_t        r_state,    w_state_nxt;
  logic [TW-1:0] r_timer,    w_timer_nxt;
  logic [1:0]    r_base_msg, w_base_nxt;
  logic [1:0]    r_msg,      w_msg_nxt;
  logic [7:0]    r_bin,      w_bin_nxt;
  logic          r_sgn,      w_sgn_nxt;
  logic [1:0]    r_dot,      w_dot_nxt;
  logic          r_wr,       w_wr_nxt;
  logic          r_val_ack,  w_val_ack_nxt;
  logic          r_pr_ack,   w_pr_ack_nxt;
  logic          r_err_ack,  w_err_ack_nxt;
  logic          r_busy;

  // Only the OP/VAL selector bit of the prompt code carries meaning.
  logic w_unused;
  assign w_unused = prompt_code[0];

  // Next-state and next-output decode: arbitration in IDLE, one-cycle LOAD,
  // error hold countdown with retrigger and restore of the base message.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_base_nxt    = r_base_msg;
    w_msg_nxt     = r_msg;
    w_bin_nxt     = r_bin;
    w_sgn_nxt     = r_sgn;
    w_dot_nxt     = r_dot;
    w_wr_nxt      = 1'b0;
    w_val_ack_nxt = 1'b0;
    w_pr_ack_nxt  = 1'b0;
    w_err_ack_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (err_req) begin
          w_msg_nxt     = MSG_ERR;
          w_err_ack_nxt = 1'b1;
          w_timer_nxt   = T_RELOAD;
          w_state_nxt   = S_ERR_HOLD;
        end else if (val_req) begin
          w_bin_nxt     = val_bin;
          w_sgn_nxt     = val_sgn;
          w_dot_nxt     = val_dot;
          w_msg_nxt     = MSG_NUM;
          w_base_nxt    = MSG_NUM;
          w_wr_nxt      = 1'b1;
          w_val_ack_nxt = 1'b1;
          w_state_nxt   = S_LOAD;
        end else if (prompt_req) begin
          w_msg_nxt    = prompt_code[1] ? MSG_VAL : MSG_OP;
          w_base_nxt   = prompt_code[1] ? MSG_VAL : MSG_OP;
          w_pr_ack_nxt = 1'b1;
          w_state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        // Requests still high here belong to the grant just given.
        w_state_nxt = S_IDLE;
      end
      S_ERR_HOLD: begin
        if (err_req) begin
          w_err_ack_nxt = 1'b1;
          w_timer_nxt   = T_RELOAD;
        end else if (r_timer != '0) begin
          w_timer_nxt = r_timer - TW'(1);
        end else begin
          w_msg_nxt   = r_base_msg;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, timer and all registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_base_msg <= MSG_NUM;
      r_msg      <= MSG_NUM;
      r_bin      <= '0;
      r_sgn      <= 1'b0;
      r_dot      <= '0;
      r_wr       <= 1'b0;
      r_val_ack  <= 1'b0;
      r_pr_ack   <= 1'b0;
      r_err_ack  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_base_msg <= w_base_nxt;
      r_msg      <= w_msg_nxt;
      r_bin      <= w_bin_nxt;
      r_sgn      <= w_sgn_nxt;
      r_dot      <= w_dot_nxt;
      r_wr       <= w_wr_nxt;
      r_val_ack  <= w_val_ack_nxt;
      r_pr_ack   <= w_pr_ack_nxt;
      r_err_ack  <= w_err_ack_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign msg        = r_msg;
  assign bin        = r_bin;
  assign sgn        = r_sgn;
  assign dot        = r_dot;
  assign wr_enable  = r_wr;
  assign led0_sel   = r_wr;
  assign val_ack    = r_val_ack;
  assign prompt_ack = r_pr_ack;
  assign err_ack    = r_err_ack;
  assign busy       = r_busy;

endmodule

// File: doc/disp_msg_scheduler.md
# disp_msg_scheduler

Sequencer and arbiter in front of the 4-digit seven-segment display decoder. It accepts display requests from three sources: numeric results, prompts (OP/VAL) and error events. It arbitrates them by fixed priority and generates the decoder's write strobe and message-select inputs. Error messages are shown for a programmable hold time, after which the display returns to the last number or prompt shown.

## Interface
- HOLD_CYCLES, default 50_000_000: clk cycles the ERR message stays on screen (≥1).
- TW, default 26: hold timer width; must satisfy 2^TW > HOLD_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- val_req  in  1  numeric display request (level, held until val_ack).
- val_bin  in  8  magnitude to show (0..255).
- val_sgn  in  1  sign; 1 shows "-".
- val_dot  in  2  decimal point position code passed to decoder.
- prompt_req  in  1  prompt request (level, held until prompt_ack).
- prompt_code  in  2  bit1=0 → OP, bit1=1 → VAL; bit0 ignored.
- err_req  in  1  error request (level, held until err_ack).
- val_ack, prompt_ack, err_ack  out  1 each  one-cycle acknowledge pulses.
- msg  out  2  decoder message select: 00 number, 01 OP, 10 VAL, 11 ERR.
- bin  out  8  decoder number bus.
- sgn  out  1  decoder sign.
- dot  out  2  decoder dot code.
- wr_enable  out  1  decoder write strobe (one cycle).
- led0_sel  out  1  decoder select, asserted together with wr_enable.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- All outputs are registered. Reset values: msg=00, bin=0, sgn=0, dot=00, wr_enable=0, led0_sel=0, all acks 0, busy=0. Internal state: state=IDLE, timer=0, base_msg=00.
- base_msg records the last non-error message and is restored after an error.
- States are IDLE, LOAD and ERR_HOLD.
- Arbitration happens in IDLE only. Priority is err_req > val_req > prompt_req. Only one request is granted per edge; losers stay pending.
- IDLE, err_req wins → msg←11, err_ack←1, timer←HOLD_CYCLES−1, state←ERR_HOLD.
- IDLE, val_req wins → bin←val_bin, sgn←val_sgn, dot←val_dot, msg←00, base_msg←00, wr_enable←1, led0_sel←1, val_ack←1, state←LOAD.
- IDLE, prompt_req wins → msg←(prompt_code[1] ? 10 : 01), base_msg←same value, prompt_ack←1, state←LOAD. No wr_enable; bin, sgn and dot are unchanged.
- LOAD lasts exactly one cycle. wr_enable, led0_sel and acks return to 0, state←IDLE. All requests are ignored in LOAD.
- ERR_HOLD, err_req high → err_ack←1 and timer←HOLD_CYCLES−1 (retrigger); msg stays 11.
- ERR_HOLD, no err_req, timer≠0 → timer←timer−1.
- ERR_HOLD, no err_req, timer=0 → msg←base_msg, state←IDLE.
- val_req and prompt_req are not acked during ERR_HOLD; they remain pending and are served after the hold ends.
- bin, sgn and dot are never changed by error handling. After restore with base_msg=00, the decoder therefore shows the last written number.
- Requesters must deassert req in the cycle after sampling ack high. A req still high in LOAD is ignored, so it cannot double-grant.

## Timing
- Grant latency: request high at edge k in IDLE → ack, wr_enable and outputs valid after edge k; they clear after edge k+1.
- Maximum throughput is one val or prompt grant per 2 cycles.
- ERR display duration: msg=11 from edge k (entry) to edge k+HOLD_CYCLES (restore), i.e. HOLD_CYCLES cycles. With HOLD_CYCLES=1, restore occurs on the next edge.
- A retrigger at edge j extends the restore to edge j+HOLD_CYCLES.
- Reset asserted mid-operation (LOAD or ERR_HOLD) forces all reset values immediately (asynchronously). Pending requests are re-arbitrated on the first edge after rst deasserts.

## Test plan
- Reset: hold rst during activity → all outputs 0, msg=00, busy=0, with no clk edge required.
- Number write: val_req, val_bin=8'd173, val_sgn=1, val_dot=2'b01 → next cycle wr_enable=led0_sel=val_ack=1, bin=173, sgn=1, dot=01, msg=00; one cycle later wr_enable=0, busy=0.
- Priority: err_req, val_req and prompt_req rise together → err_ack first and msg=11. After the hold expires: val served, then prompt. Exactly one ack per grant.
- Prompt: prompt_code=2'b10 → msg=10, prompt_ack pulse, no wr_enable; prompt_code=2'b01 → msg=01.
- ERR hold/restore (HOLD_CYCLES=4): write number 42, then err_req → msg=11 for exactly 4 cycles, then msg=00. A val_req issued during the hold is acked only after restore.
- Retrigger and reset mid-hold: second err_req 2 cycles into the hold → restore 4 cycles after the second ack. rst pulse during ERR_HOLD → msg=00, state IDLE, timer cleared.
